rr_gate_arbiter: RTL and testbench

RR_GATE_ARBITER -- requirements
Module: rr_gate_arbiter

---
 rtl/rr_gate_arbiter.sv | 110 +++++++++++
 tb/tb_rr_gate_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_gate_arbiter.sv
// Round-robin arbiter that gates one of four byte streams onto a single
// registered output, limiting each owner to HOLD_MAX consecutive beats.
module rr_gate_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] din,
    output logic [3:0]  gnt,
    output logic [7:0]  x,
    output logic        x_valid,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] k, k_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] gnt_n;
    logic [1:0] arb_ptr;
    logic [1:0] winner;
    logic       beat;
    logic       rel;
    logic       any_req;

    assign any_req = |req;
    assign busy    = (state == OWN);

    always_comb begin
        beat    = (state == OWN) && req[k];
        rel     = (state == OWN) && (!req[k] || (cnt == CNT_LAST));
        // A release arbitrates in the same cycle from the slot after the owner
        arb_ptr = rel ? (k + 2'd1) : ptr;
    end

    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = arb_ptr;
        found  = 1'b0;
        idx    = arb_ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = arb_ptr + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        k_n     = k;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n = OWN;
                    k_n     = winner;
                    cnt_n   = '0;
                end
            end
            OWN: begin
                if (rel) begin
                    ptr_n = arb_ptr;
                    if (any_req) begin
                        k_n   = winner;
                        cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (beat) begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        gnt_n = (state_n == OWN) ? (4'b0001 << k_n) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            k       <= '0;
            cnt     <= '0;
            gnt     <= '0;
            x       <= '0;
            x_valid <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            k       <= k_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            x       <= beat ? din[{k, 3'b000} +: 8] : '0;
            x_valid <= beat;
        end
    end

endmodule

// File: tb/tb_rr_gate_arbiter.sv
// Bench for rr_gate_arbiter: directed vector table, hand sequences for reset
// and HOLD_MAX=1, then random traffic against a behavioural model.
module tb_rr_gate_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] din = '0;
    logic [3:0]  gnt4, gnt1;
    logic [7:0]  x4, x1;
    logic        xv4, xv1, busy4, busy1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rr_gate_arbiter #(.HOLD_MAX(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt4), .x(x4), .x_valid(xv4), .busy(busy4)
    );

    rr_gate_arbiter #(.HOLD_MAX(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt1), .x(x1), .x_valid(xv1), .busy(busy1)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic [7:0]  x;
        logic        xv;
    } vec_t;

    vec_t tbl[$];

    // Model: owner index (-1 = none), beats taken, and where the next scan starts
    int         m_owner[2];
    int         m_beats[2];
    int         m_start[2];
    logic [3:0] m_gnt[2];
    logic [7:0] m_x[2];
    logic       m_v[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_beats[m] = 0;
            m_start[m] = 0;
            m_gnt[m]   = '0;
            m_x[m]     = '0;
            m_v[m]     = 1'b0;
        end
    endfunction

    function automatic void model_step(input int m, input int hold);
        bit pick;
        if (!rst_n) begin
            m_owner[m] = -1; m_beats[m] = 0; m_start[m] = 0;
            m_gnt[m] = '0; m_x[m] = '0; m_v[m] = 1'b0;
            return;
        end
        m_v[m] = (m_owner[m] >= 0) && req[m_owner[m]];
        m_x[m] = m_v[m] ? 8'((din >> (8 * m_owner[m])) & 32'hFF) : 8'h00;
        if (m_v[m]) m_beats[m]++;
        pick = (m_owner[m] < 0);
        if (m_owner[m] >= 0 && (!req[m_owner[m]] || m_beats[m] == hold)) begin
            m_start[m] = (m_owner[m] + 1) % 4;
            pick = 1'b1;
        end
        if (pick) begin
            m_owner[m] = -1;
            for (int off = 0; off < 4; off++) begin
                int idx;
                idx = (m_start[m] + off) % 4;
                if (m_owner[m] < 0 && req[idx]) m_owner[m] = idx;
            end
            m_beats[m] = 0;
        end
        m_gnt[m] = (m_owner[m] >= 0) ? 4'(1 << m_owner[m]) : 4'b0000;
    endfunction

    task automatic cmp_models();
        check("m4_gnt",  32'(gnt4),  32'(m_gnt[0]));
        check("m4_x",    32'(x4),    32'(m_x[0]));
        check("m4_xv",   32'(xv4),   32'(m_v[0]));
        check("m4_busy", 32'(busy4), 32'(m_gnt[0] != 0));
        check("m1_gnt",  32'(gnt1),  32'(m_gnt[1]));
        check("m1_x",    32'(x1),    32'(m_x[1]));
        check("m1_xv",   32'(xv1),   32'(m_v[1]));
        check("m1_busy", 32'(busy1), 32'(m_gnt[1] != 0));
        check("onehot4", 32'($onehot0(gnt4)), 32'd1);
        check("onehot1", 32'($onehot0(gnt1)), 32'd1);
    endtask

    task automatic apply(input logic r, input logic [3:0] q, input logic [31:0] d);
        rst_n = r;
        req   = q;
        din   = d;
        if (!r) model_reset();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 4);
        model_step(1, 1);
        @(negedge clk);
        cmp_models();
    endtask

    function automatic void add(input logic r, input logic [3:0] q, input logic [31:0] d,
                                input logic [3:0] g, input logic [7:0] xx, input logic v);
        vec_t e;
        e.rst_n = r; e.req = q; e.din = d; e.gnt = g; e.x = xx; e.xv = v;
        tbl.push_back(e);
    endfunction

    initial begin
        logic [3:0] g;
        logic [3:0] cur_req;

        // Idle gating
        repeat (5) add(1'b1, 4'b0000, 32'hFFFF_FFFF, 4'b0000, 8'h00, 1'b0);
        // Single requester, continuous re-grant after HOLD_MAX
        add(1'b1, 4'b0100, 32'h00A5_0000, 4'b0100, 8'h00, 1'b0);
        repeat (6) add(1'b1, 4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5, 1'b1);
        // Early drop by owner 1 with only requester 3 waiting
        add(1'b0, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0);
        add(1'b1, 4'b0010, 32'h1100_3300, 4'b0010, 8'h00, 1'b0);
        repeat (2) add(1'b1, 4'b0010, 32'h1100_3300, 4'b0010, 8'h33, 1'b1);
        add(1'b1, 4'b1000, 32'h1100_3300, 4'b1000, 8'h00, 1'b0);
        add(1'b1, 4'b1000, 32'h1100_3300, 4'b1000, 8'h11, 1'b1);
        // Fairness with all four requesting
        add(1'b0, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0);
        add(1'b1, 4'b1111, 32'h4030_2010, 4'b0001, 8'h00, 1'b0);
        for (int o = 0; o < 4; o++) begin
            for (int b = 0; b < 4; b++) begin
                g = (b == 3) ? 4'(1 << ((o + 1) % 4)) : 4'(1 << o);
                add(1'b1, 4'b1111, 32'h4030_2010, g, 8'(8'h10 * (o + 1)), 1'b1);
            end
        end
        add(1'b1, 4'b1111, 32'h4030_2010, 4'b0001, 8'h10, 1'b1);

        // Reset takes effect with no clock edge
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_gnt",  32'(gnt4),  32'h0);
        check("rst_x",    32'(x4),    32'h0);
        check("rst_xv",   32'(xv4),   32'h0);
        check("rst_busy", 32'(busy4), 32'h0);
        @(negedge clk);

        foreach (tbl[i]) begin
            apply(tbl[i].rst_n, tbl[i].req, tbl[i].din);
            tick();
            check("tbl_gnt",  32'(gnt4),  32'(tbl[i].gnt));
            check("tbl_x",    32'(x4),    32'(tbl[i].x));
            check("tbl_xv",   32'(xv4),   32'(tbl[i].xv));
            check("tbl_busy", 32'(busy4), 32'(tbl[i].gnt != 0));
        end

        // Reset during the second beat of owner 3, then restart from ptr 0
        apply(1'b0, 4'b0000, 32'h0);
        tick();
        apply(1'b1, 4'b1000, 32'hCC00_0000);
        tick();
        check("mid_gnt0", 32'(gnt4), 32'h8);
        tick();
        check("mid_x1", 32'(x4), 32'hCC);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_gnt", 32'(gnt4), 32'h0);
        check("mid_x",   32'(x4),   32'h0);
        check("mid_xv",  32'(xv4),  32'h0);
        check("mid_busy", 32'(busy4), 32'h0);
        tick();
        apply(1'b1, 4'b1010, 32'h0000_DD00);
        tick();
        check("post_gnt", 32'(gnt4), 32'h2);
        tick();
        check("post_x", 32'(x4), 32'hDD);

        // HOLD_MAX=1 alternates every cycle
        apply(1'b0, 4'b0000, 32'h0);
        tick();
        apply(1'b1, 4'b0011, 32'h0000_BBAA);
        tick();
        check("h1_gnt_a", 32'(gnt1), 32'h1);
        check("h1_xv_a",  32'(xv1),  32'h0);
        tick();
        check("h1_gnt_b", 32'(gnt1), 32'h2);
        check("h1_x_b",   32'(x1),   32'hAA);
        tick();
        check("h1_gnt_c", 32'(gnt1), 32'h1);
        check("h1_x_c",   32'(x1),   32'hBB);
        tick();
        check("h1_gnt_d", 32'(gnt1), 32'h2);
        check("h1_x_d",   32'(x1),   32'hAA);

        // Random traffic, requests mostly held to exercise full bursts
        cur_req = 4'b0000;
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r >= 75) cur_req = 4'($urandom);
            apply(r >= 2, cur_req, $urandom);
            tick();
            if (r == 50) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 cmp_models();
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
